neuron_layer_ctrl: RTL and testbench

Sequencer for a layer of `neuron` instances that share one weight-load bus and one start strobe. It streams weights and biases from an upstream valid/ready source into each neuron's weight registers. On command it fires all neurons together, collects each neuron's 64-bit activation on its `done`, and streams the activations out in neuron-index order. It sits between the weight/result memory interface and the neuron array.

---
 rtl/neuron_layer_ctrl.sv | 138 +++++++++++++
 tb/tb_neuron_layer_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_ctrl.sv
// neuron_layer_ctrl: streams weights into a neuron array, fires it, collects and drains activations
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load/i_run IDLE-only commands;
//   i_w_valid/i_w_data/o_w_ready weight stream in; o_neuron_write_weight/o_neuron_weight_sel/
//   o_neuron_weight_bus per-neuron weight writes; o_neuron_start broadcast start;
//   i_neuron_done/i_neuron_act per-neuron results; o_result_valid/o_result_data/i_result_ready
//   activation stream out; o_busy not idle; o_loaded full weight set present.
module neuron_layer_ctrl #(
    parameter int NUM_NEURONS = 8,
    parameter int NUM_WEIGHTS = 400
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_load,
    input  logic                      i_run,
    input  logic                      i_w_valid,
    input  logic [63:0]               i_w_data,
    output logic                      o_w_ready,
    output logic [NUM_NEURONS-1:0]    o_neuron_write_weight,
    output logic [8:0]                o_neuron_weight_sel,
    output logic [63:0]               o_neuron_weight_bus,
    output logic                      o_neuron_start,
    input  logic [NUM_NEURONS-1:0]    i_neuron_done,
    input  logic [NUM_NEURONS*64-1:0] i_neuron_act,
    output logic                      o_result_valid,
    output logic [63:0]               o_result_data,
    input  logic                      i_result_ready,
    output logic                      o_busy,
    output logic                      o_loaded
);
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;
    state_t                  r_state;
    logic [NW-1:0]           r_n_idx;
    logic [8:0]              r_w_idx;
    logic [NW-1:0]           r_r_idx;
    logic [NUM_NEURONS-1:0]  r_mask;
    logic [63:0]             r_slot [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]  w_onehot;
    logic [NUM_NEURONS-1:0]  w_new;
    logic [NUM_NEURONS-1:0]  w_mask_next;
    logic [63:0]             w_first;
    logic [NW-1:0]           w_r_next;
    logic                    w_wrap;
    logic                    w_last_beat;
    logic                    w_last_res;
    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) w_onehot[i] = (r_n_idx == NW'(i));
        w_new       = i_neuron_done & ~r_mask;
        w_mask_next = r_mask | i_neuron_done;
        // slot 0 may be captured on the same edge that enters DRAIN
        w_first     = w_new[0] ? i_neuron_act[63:0] : r_slot[0];
        w_r_next    = r_r_idx + 1'b1;
        w_wrap      = (r_w_idx == 9'(NUM_WEIGHTS));
        w_last_beat = w_wrap && (r_n_idx == NW'(NUM_NEURONS - 1));
        w_last_res  = (r_r_idx == NW'(NUM_NEURONS - 1));
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state               <= S_IDLE;
            r_n_idx               <= '0;
            r_w_idx               <= '0;
            r_r_idx               <= '0;
            r_mask                <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) r_slot[i] <= '0;
            o_w_ready             <= 1'b0;
            o_neuron_write_weight <= '0;
            o_neuron_weight_sel   <= '0;
            o_neuron_weight_bus   <= '0;
            o_neuron_start        <= 1'b0;
            o_result_valid        <= 1'b0;
            o_result_data         <= '0;
            o_busy                <= 1'b0;
            o_loaded              <= 1'b0;
        end else begin
            o_neuron_write_weight <= '0;
            o_neuron_start        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_load) begin
                        r_state   <= S_LOAD;
                        r_n_idx   <= '0;
                        r_w_idx   <= '0;
                        o_loaded  <= 1'b0;
                        o_w_ready <= 1'b1;
                        o_busy    <= 1'b1;
                    end else if (i_run && o_loaded) begin
                        r_state        <= S_START;
                        o_neuron_start <= 1'b1;
                        o_busy         <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (i_w_valid) begin
                        o_neuron_write_weight <= w_onehot;
                        o_neuron_weight_sel   <= r_w_idx;
                        o_neuron_weight_bus   <= i_w_data;
                        r_w_idx               <= w_wrap ? 9'd0 : r_w_idx + 9'd1;
                        r_n_idx               <= w_wrap ? r_n_idx + 1'b1 : r_n_idx;
                        if (w_last_beat) begin
                            r_state   <= S_IDLE;
                            o_w_ready <= 1'b0;
                            o_loaded  <= 1'b1;
                            o_busy    <= 1'b0;
                        end
                    end
                end
                S_START: begin
                    r_mask  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_mask <= w_mask_next;
                    for (int i = 0; i < NUM_NEURONS; i++)
                        if (w_new[i]) r_slot[i] <= i_neuron_act[i*64 +: 64];
                    if (&w_mask_next) begin
                        r_state        <= S_DRAIN;
                        r_r_idx        <= '0;
                        o_result_valid <= 1'b1;
                        o_result_data  <= w_first;
                    end
                end
                S_DRAIN: begin
                    if (i_result_ready) begin
                        if (w_last_res) begin
                            r_state        <= S_IDLE;
                            o_result_valid <= 1'b0;
                            o_busy         <= 1'b0;
                        end else begin
                            r_r_idx       <= w_r_next;
                            o_result_data <= r_slot[w_r_next];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// tb_neuron_layer_ctrl: randomized self-checking bench for neuron_layer_ctrl against a beat-level model
module tb_neuron_layer_ctrl;
    localparam int N = 2;
    localparam int W = 4;
    localparam int TOTAL = N * (W + 1);
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load = 1'b0;
    logic            run = 1'b0;
    logic            w_valid = 1'b0;
    logic [63:0]     w_data = '0;
    logic [N-1:0]    done = '0;
    logic [N*64-1:0] act = '0;
    logic            result_ready = 1'b0;
    logic            w_ready;
    logic [N-1:0]    wr;
    logic [8:0]      sel;
    logic [63:0]     bus;
    logic            start;
    logic            rv;
    logic [63:0]     rd;
    logic            busy;
    logic            loaded;
    int              n_chk = 0;
    int              n_err = 0;
    bit              m_loaded = 1'b0;
    int              dly [N];
    logic [63:0]     act_v [N];
    logic [63:0]     wdat [TOTAL];

    neuron_layer_ctrl #(.NUM_NEURONS(N), .NUM_WEIGHTS(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_run(run),
        .i_w_valid(w_valid), .i_w_data(w_data), .o_w_ready(w_ready),
        .o_neuron_write_weight(wr), .o_neuron_weight_sel(sel), .o_neuron_weight_bus(bus),
        .o_neuron_start(start), .i_neuron_done(done), .i_neuron_act(act),
        .o_result_valid(rv), .o_result_data(rd), .i_result_ready(result_ready),
        .o_busy(busy), .o_loaded(loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_w_ready"}, w_ready, 0);
        chk({tag, "_wr"}, wr, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_bus"}, bus, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_rv"}, rv, 0);
        chk({tag, "_rd"}, rd, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_loaded"}, loaded, 0);
    endtask

    // mode 0: valid every cycle, 1: valid every other cycle with stray commands, 2: random valid
    task automatic do_load(input int mode, input bit seq);
        int b;
        int pend;
        int cyc;
        bit v;
        for (int i = 0; i < TOTAL; i++) wdat[i] = seq ? $realtobits(real'(i + 1)) : {$urandom, $urandom};
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
        chk("ld_ready", w_ready, 1);
        chk("ld_busy", busy, 1);
        chk("ld_loaded_clr", loaded, 0);
        m_loaded = 1'b0;
        b = 0;
        pend = -1;
        cyc = 0;
        while (1) begin
            if (pend >= 0) begin
                chk("wr_onehot", wr, N'(1) << (pend / (W + 1)));
                chk("wr_sel", sel, 64'(pend % (W + 1)));
                chk("wr_bus", bus, wdat[pend]);
            end else chk("wr_idle", wr, 0);
            if (b == TOTAL) break;
            chk("ld_ready_on", w_ready, 1);
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
            w_valid = v;
            w_data = v ? wdat[b] : {$urandom, $urandom};
            if (mode == 1) begin
                load = 1'($urandom % 2);
                run = 1'($urandom % 2);
            end
            pend = v ? b : -1;
            if (v) b++;
            cyc++;
            if (cyc > 1000) begin
                chk("ld_timeout", 1, 0);
                break;
            end
            @(negedge clk);
            load = 1'b0;
            run = 1'b0;
        end
        w_valid = 1'b0;
        chk("ld_ready_off", w_ready, 0);
        chk("ld_loaded", loaded, 1);
        chk("ld_busy_off", busy, 0);
        m_loaded = 1'b1;
    endtask

    // stub neurons: neuron i raises done dly[i] cycles after the start cycle; act is corrupted afterwards
    task automatic do_run(input bit level, input int stall0, input bit rnd);
        int kmax;
        int stall;
        kmax = 0;
        for (int i = 0; i < N; i++) if (dly[i] > kmax) kmax = dly[i];
        for (int i = 0; i < N; i++) act[i*64 +: 64] = act_v[i];
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
        chk("run_start", start, 1);
        chk("run_busy", busy, 1);
        for (int k = 1; k <= kmax + 1; k++) begin
            @(negedge clk);
            chk("run_start_pulse", start, 0);
            chk("run_valid_time", rv, 64'(k > kmax));
            for (int i = 0; i < N; i++) begin
                done[i] = level ? (k >= dly[i]) : (k == dly[i] && k <= kmax);
                act[i*64 +: 64] = (k <= dly[i]) ? act_v[i] : {$urandom, $urandom};
            end
        end
        for (int r = 0; r < N; r++) begin
            stall = (r == 0) ? stall0 : (rnd ? int'($urandom % 3) : 0);
            for (int s = 0; s < stall; s++) begin
                result_ready = 1'b0;
                chk("drain_stall_valid", rv, 1);
                chk("drain_stall_data", rd, act_v[r]);
                @(negedge clk);
            end
            result_ready = 1'b1;
            chk("drain_valid", rv, 1);
            chk("drain_data", rd, act_v[r]);
            chk("drain_busy", busy, 1);
            @(negedge clk);
            result_ready = 1'b0;
        end
        chk("drain_end_valid", rv, 0);
        chk("drain_end_busy", busy, 0);
        chk("drain_keep_loaded", loaded, 1);
        done = '0;
    endtask

    initial begin
        repeat (5) begin
            @(negedge clk);
            load = 1'($urandom % 2);
            run = 1'($urandom % 2);
            w_valid = 1'($urandom % 2);
            w_data = {$urandom, $urandom};
            done = N'($urandom);
            act = {$urandom, $urandom, $urandom, $urandom};
            result_ready = 1'($urandom % 2);
            #1 check_reset("rst");
        end
        @(negedge clk);
        {load, run, w_valid, w_data, done, act, result_ready} = '0;
        rst_n = 1'b1;
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
        chk("run_unloaded_busy", busy, 0);
        chk("run_unloaded_start", start, 0);

        do_load(0, 1'b1);
        do_load(1, 1'b1);
        dly[0] = 3;
        dly[1] = 7;
        act_v[0] = $realtobits(0.25);
        act_v[1] = $realtobits(-0.5);
        do_run(1'b0, 0, 1'b0);
        dly[0] = 4;
        dly[1] = 4;
        act_v[0] = {$urandom, $urandom};
        act_v[1] = {$urandom, $urandom};
        do_run(1'b1, 3, 1'b0);

        repeat (8) begin
            if ($urandom % 3 == 0) do_load(2, 1'b0);
            for (int i = 0; i < N; i++) begin
                dly[i] = int'($urandom_range(1, 8));
                act_v[i] = {$urandom, $urandom};
            end
            do_run(1'($urandom % 2), int'($urandom % 3), 1'b1);
        end

        dly[0] = 10;
        dly[1] = 12;
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
        chk("wait_start", start, 1);
        repeat (3) @(negedge clk);
        chk("wait_busy", busy, 1);
        rst_n = 1'b0;
        #1 check_reset("rst_wait");
        @(negedge clk) rst_n = 1'b1;
        m_loaded = 1'b0;
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
        chk("rerun_busy", busy, 0);
        chk("rerun_start", start, 0);
        @(negedge clk);
        chk("rerun_busy2", busy, 0);
        do_load(2, 1'b0);
        dly[0] = 2;
        dly[1] = 1;
        act_v[0] = {$urandom, $urandom};
        act_v[1] = {$urandom, $urandom};
        do_run(1'b0, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
